// File: rtl/br_flow_xbar_rr_return.sv
// Return-path crossbar: routes responder pushes to initiator pops by push_src_id, one RR arbiter per pop.
// Optional per-pop stall counters (stall_cnt port) when BR_FLOW_XBAR_RETURN_STALL_CNT_EN is defined.
`timescale 1ns/1ps
module br_flow_xbar_rr_return #(
  parameter int NumPushFlows = 2,
  parameter int NumPopFlows  = 2,
  parameter int Width        = 1,
  localparam int SrcIdWidth  = $clog2(NumPopFlows)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NumPushFlows-1:0]                  push_valid,
  output logic [NumPushFlows-1:0]                  push_ready,
  input  logic [NumPushFlows-1:0][Width-1:0]       push_data,
  input  logic [NumPushFlows-1:0][SrcIdWidth-1:0]  push_src_id,
  output logic [NumPopFlows-1:0]                   pop_valid,
  input  logic [NumPopFlows-1:0]                   pop_ready,
  output logic [NumPopFlows-1:0][Width-1:0]        pop_data
`ifdef BR_FLOW_XBAR_RETURN_STALL_CNT_EN
  ,
  output logic [NumPopFlows-1:0][15:0]             stall_cnt
`endif
);

  localparam int PtrWidth = (NumPushFlows > 1) ? $clog2(NumPushFlows) : 1;
  localparam logic [SrcIdWidth:0] NumPopFlowsId = (SrcIdWidth+1)'(NumPopFlows);

  logic [NumPushFlows-1:0]                    src_in_range;
  logic [NumPopFlows-1:0][NumPushFlows-1:0]   request;
  logic [NumPopFlows-1:0][NumPushFlows-1:0]   grant;
  logic [NumPopFlows-1:0]                     any_grant;
  logic [NumPopFlows-1:0][PtrWidth-1:0]       winner;
  logic [NumPopFlows-1:0]                     load;

  logic [NumPopFlows-1:0][PtrWidth-1:0]       ptr_q, ptr_d;
  logic [NumPopFlows-1:0]                     pop_valid_q, pop_valid_d;
  logic [NumPopFlows-1:0][Width-1:0]          pop_data_q, pop_data_d;

  always_comb begin
    src_in_range = '0;
    request      = '0;
    for (int i = 0; i < NumPushFlows; i++) begin
      src_in_range[i] = ({1'b0, push_src_id[i]} < NumPopFlowsId);
      for (int j = 0; j < NumPopFlows; j++) begin
        request[j][i] = push_valid[i] && (push_src_id[i] == SrcIdWidth'(j));
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NumPopFlows; j++) begin
      load[j] = !pop_valid_q[j] || pop_ready[j];
    end
  end

  // Search starts at ptr_q and wraps; the first requester found wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    any_grant = '0;
    winner    = '0;
    for (int j = 0; j < NumPopFlows; j++) begin
      for (int k = 0; k < NumPushFlows; k++) begin
        idx = int'(ptr_q[j]) + k;
        if (idx >= NumPushFlows) idx = idx - NumPushFlows;
        if (!any_grant[j] && request[j][idx]) begin
          any_grant[j]   = 1'b1;
          grant[j][idx]  = 1'b1;
          winner[j]      = PtrWidth'(idx);
        end
      end
    end
  end

  always_comb begin
    push_ready = '0;
    for (int i = 0; i < NumPushFlows; i++) begin
      if (rst_n && src_in_range[i]) begin
        push_ready[i] = grant[push_src_id[i]][i] && load[push_src_id[i]];
      end
    end
  end

  // A stage with no winner but free to load drains to empty; data is left as-is.
  always_comb begin
    ptr_d       = ptr_q;
    pop_valid_d = pop_valid_q;
    pop_data_d  = pop_data_q;
    for (int j = 0; j < NumPopFlows; j++) begin
      if (load[j]) begin
        pop_valid_d[j] = any_grant[j];
        if (any_grant[j]) begin
          pop_data_d[j] = push_data[winner[j]];
          ptr_d[j]      = (int'(winner[j]) == NumPushFlows - 1) ? '0 : winner[j] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      pop_valid_q <= '0;
      pop_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;

`ifdef BR_FLOW_XBAR_RETURN_STALL_CNT_EN
  logic [NumPopFlows-1:0][15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    for (int j = 0; j < NumPopFlows; j++) begin
      if (pop_valid_q[j] && !pop_ready[j] && (stall_cnt_q[j] != 16'hFFFF)) begin
        stall_cnt_d[j] = stall_cnt_q[j] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  for (genvar gi = 0; gi < NumPushFlows; gi++) begin : g_push_chk
    a_src_id_range: assert property (@(posedge clk) disable iff (!rst_n)
      push_valid[gi] |-> src_in_range[gi]);
    a_push_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (push_valid[gi] && !push_ready[gi]) |=>
        (push_valid[gi] && $stable(push_data[gi]) && $stable(push_src_id[gi])));
  end
  for (genvar gj = 0; gj < NumPopFlows; gj++) begin : g_pop_chk
    a_pop_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (pop_valid[gj] && !pop_ready[gj]) |=> (pop_valid[gj] && $stable(pop_data[gj])));
  end
`endif

endmodule

// File: tb/tb_br_flow_xbar_rr_return.sv
// Bench for br_flow_xbar_rr_return: directed vector table, corner sequences, random traffic vs reference model.
`timescale 1ns/1ps
module tb_br_flow_xbar_rr_return;
  localparam int NPUSH = 3;
  localparam int NPOP  = 2;
  localparam int W     = 4;
  localparam int SW    = 1;

  logic                        clk;
  logic                        rst_n;
  logic [NPUSH-1:0]            push_valid;
  logic [NPUSH-1:0]            push_ready;
  logic [NPUSH-1:0][W-1:0]     push_data;
  logic [NPUSH-1:0][SW-1:0]    push_src_id;
  logic [NPOP-1:0]             pop_valid;
  logic [NPOP-1:0]             pop_ready;
  logic [NPOP-1:0][W-1:0]      pop_data;
`ifdef BR_FLOW_XBAR_RETURN_STALL_CNT_EN
  logic [NPOP-1:0][15:0]       stall_cnt;
`endif

  br_flow_xbar_rr_return #(.NumPushFlows(NPUSH), .NumPopFlows(NPOP), .Width(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_data   (push_data),
    .push_src_id (push_src_id),
    .pop_valid   (pop_valid),
    .pop_ready   (pop_ready),
    .pop_data    (pop_data)
`ifdef BR_FLOW_XBAR_RETURN_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NPOP*W-1:0] lane_mask(input logic [NPOP-1:0] v);
    lane_mask = '0;
    for (int j = 0; j < NPOP; j++) if (v[j]) lane_mask[j*W +: W] = '1;
  endfunction

  // Reference: each pop is a one-entry slot with a "next favoured responder" index.
  logic [NPUSH-1:0]        m_rdy;
  logic [NPOP-1:0]         m_valid;
  logic [NPOP-1:0][W-1:0]  m_data;
  int                      m_ptr   [NPOP];
  int                      m_stall [NPOP];

  task automatic model_reset();
    m_rdy   = '0;
    m_valid = '0;
    m_data  = '0;
    for (int j = 0; j < NPOP; j++) begin
      m_ptr[j]   = 0;
      m_stall[j] = 0;
    end
  endtask

  task automatic model_check_step();
    int win [NPOP];
    logic [NPOP-1:0] free;
    for (int j = 0; j < NPOP; j++) begin
      free[j] = !m_valid[j] || pop_ready[j];
      win[j]  = -1;
      for (int k = 0; k < NPUSH; k++) begin
        int i;
        i = (m_ptr[j] + k) % NPUSH;
        if (win[j] < 0 && push_valid[i] && int'(push_src_id[i]) == j) win[j] = i;
      end
    end
    for (int i = 0; i < NPUSH; i++)
      m_rdy[i] = push_valid[i] && (win[push_src_id[i]] == i) && free[push_src_id[i]];
    chk("model_push_ready", 32'(push_ready), 32'(m_rdy));
    chk("model_pop_valid", 32'(pop_valid), 32'(m_valid));
    chk("model_pop_data", 32'(pop_data & lane_mask(m_valid)), 32'(m_data & lane_mask(m_valid)));
`ifdef BR_FLOW_XBAR_RETURN_STALL_CNT_EN
    for (int j = 0; j < NPOP; j++) chk("model_stall_cnt", 32'(stall_cnt[j]), 32'(m_stall[j]));
`endif
    for (int j = 0; j < NPOP; j++) begin
      if (m_valid[j] && !pop_ready[j] && m_stall[j] < 65535) m_stall[j]++;
      if (free[j]) begin
        m_valid[j] = (win[j] >= 0);
        if (win[j] >= 0) begin
          m_data[j] = push_data[win[j]];
          m_ptr[j]  = (win[j] + 1) % NPUSH;
        end
      end
    end
  endtask

  task automatic apply(input logic [NPUSH-1:0] pv, input logic [NPUSH-1:0] src,
                       input logic [NPUSH*W-1:0] d, input logic [NPOP-1:0] pr,
                       input logic [NPUSH-1:0] er, input logic [NPOP-1:0] epv,
                       input logic [NPOP*W-1:0] epd);
    push_valid  = pv;
    push_src_id = src;
    push_data   = d;
    pop_ready   = pr;
    @(negedge clk);
    chk("vec_push_ready", 32'(push_ready), 32'(er));
    model_check_step();
    @(posedge clk);
    #1;
    chk("vec_pop_valid", 32'(pop_valid), 32'(epv));
    chk("vec_pop_data", 32'(pop_data & lane_mask(epv)), 32'(epd));
  endtask

  typedef struct {
    logic [NPUSH-1:0]   pv;
    logic [NPUSH-1:0]   src;
    logic [NPUSH*W-1:0] data;
    logic [NPOP-1:0]    prdy;
    logic [NPUSH-1:0]   exp_rdy;
    logic [NPOP-1:0]    exp_pv;
    logic [NPOP*W-1:0]  exp_pd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    // single route, then two responders alternating on pop0
    tbl[0] = '{3'b001, 3'b001, 12'h005, 2'b11, 3'b001, 2'b10, 8'h50};
    tbl[1] = '{3'b000, 3'b000, 12'h000, 2'b11, 3'b000, 2'b00, 8'h00};
    tbl[2] = '{3'b011, 3'b000, 12'h0A3, 2'b11, 3'b001, 2'b01, 8'h03};
    tbl[3] = '{3'b011, 3'b000, 12'h0A3, 2'b11, 3'b010, 2'b01, 8'h0A};
    tbl[4] = '{3'b011, 3'b000, 12'h0A3, 2'b11, 3'b001, 2'b01, 8'h03};
    tbl[5] = '{3'b011, 3'b000, 12'h0A3, 2'b11, 3'b010, 2'b01, 8'h0A};
    tbl[6] = '{3'b001, 3'b000, 12'h003, 2'b11, 3'b001, 2'b01, 8'h03};
    tbl[7] = '{3'b000, 3'b000, 12'h000, 2'b11, 3'b000, 2'b00, 8'h00};

    model_reset();
    rst_n       = 1'b0;
    push_valid  = 3'b001;
    push_src_id = '0;
    push_data   = 12'h007;
    pop_ready   = 2'b11;
    #12;
    chk("rst_push_ready", 32'(push_ready), 32'h0);
    chk("rst_pop_valid", 32'(pop_valid), 32'h0);
    chk("rst_pop_data", 32'(pop_data), 32'h0);
    push_valid = '0;
    push_data  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int c = 0; c < 10; c++) begin
      apply(3'b000, 3'b000, 12'h000, 2'b11, 3'b000, 2'b00, 8'h00);
      chk("idle_pop_data", 32'(pop_data), 32'h0);
    end

    for (int v = 0; v < 8; v++)
      apply(tbl[v].pv, tbl[v].src, tbl[v].data, tbl[v].prdy, tbl[v].exp_rdy, tbl[v].exp_pv, tbl[v].exp_pd);

    // pop0 backpressured for 5 cycles while pop1 streams
    apply(3'b011, 3'b010, 12'h061, 2'b10, 3'b011, 2'b11, 8'h61);
    for (int s = 0; s < 5; s++)
      apply(3'b011, 3'b010, {4'h0, 4'(7 + s), 4'h2}, 2'b10, 3'b010, 2'b11, {4'(7 + s), 4'h1});
`ifdef BR_FLOW_XBAR_RETURN_STALL_CNT_EN
    chk("stall_cnt0", 32'(stall_cnt[0]), 32'd5);
    chk("stall_cnt1", 32'(stall_cnt[1]), 32'd0);
`endif
    apply(3'b001, 3'b000, 12'h002, 2'b11, 3'b001, 2'b01, 8'h02);

    // pointer must hold while the winner's load is blocked
    apply(3'b000, 3'b000, 12'h000, 2'b11, 3'b000, 2'b00, 8'h00);
    apply(3'b010, 3'b000, 12'h0C0, 2'b11, 3'b010, 2'b01, 8'h0C);
    for (int s = 0; s < 3; s++)
      apply(3'b011, 3'b000, 12'h0ED, 2'b10, 3'b000, 2'b01, 8'h0C);
    apply(3'b011, 3'b000, 12'h0ED, 2'b11, 3'b001, 2'b01, 8'h0D);

    // leave pop0's pointer at responder 1, then reset mid-stream
    apply(3'b010, 3'b000, 12'h0E0, 2'b11, 3'b010, 2'b01, 8'h0E);
    apply(3'b001, 3'b000, 12'h00F, 2'b11, 3'b001, 2'b01, 8'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pop_valid", 32'(pop_valid), 32'h0);
    chk("rst_mid_push_ready", 32'(push_ready), 32'h0);
    model_reset();
    push_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(3'b011, 3'b000, 12'h021, 2'b11, 3'b001, 2'b01, 8'h01);

    // random traffic; unaccepted pushes are held stable
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < NPOP; j++) pop_ready[j] = ($urandom % 4) != 0;
      for (int i = 0; i < NPUSH; i++) begin
        if (!push_valid[i] || m_rdy[i]) begin
          push_valid[i]  = ($urandom % 3) != 0;
          push_src_id[i] = 1'($urandom);
          push_data[i]   = 4'($urandom);
        end
      end
      @(negedge clk);
      model_check_step();
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
